// File: rtl/mul_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sched_if
//  Description : Bundle of requester handshakes, multiplier-tree operand and
//                product lines and the response port of the shared-multiplier
//                scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_sched_if #(
    parameter int W    = 58,
    parameter int TAGW = 4
);
    // requester 0 (FP multiply path)
    logic            in0_valid;
    logic            in0_ready;
    logic [W-1:0]    in0_a;
    logic [W-1:0]    in0_b;
    logic [TAGW-1:0] in0_tag;
    // requester 1 (divide / Newton iteration path)
    logic            in1_valid;
    logic            in1_ready;
    logic [W-1:0]    in1_a;
    logic [W-1:0]    in1_b;
    logic [TAGW-1:0] in1_tag;
    // external multiplier tree
    logic [W-1:0]    mt_a;
    logic [W-1:0]    mt_b;
    logic [2*W-1:0]  mt_out;
    // response port
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [TAGW-1:0] rsp_tag;
    logic [2*W-1:0]  rsp_prod;
    logic [1:0]      inflight;

    // scheduler side
    modport slave (
        input  in0_valid, in0_a, in0_b, in0_tag,
        input  in1_valid, in1_a, in1_b, in1_tag,
        input  mt_out, rsp_ready,
        output in0_ready, in1_ready, mt_a, mt_b,
        output rsp_valid, rsp_id, rsp_tag, rsp_prod, inflight
    );

    // requester / consumer / tree side
    modport master (
        output in0_valid, in0_a, in0_b, in0_tag,
        output in1_valid, in1_a, in1_b, in1_tag,
        output mt_out, rsp_ready,
        input  in0_ready, in1_ready, mt_a, mt_b,
        input  rsp_valid, rsp_id, rsp_tag, rsp_prod, inflight
    );
endinterface
`default_nettype wire

// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sched
//  Description : Round-robin scheduler sharing one WxW multiplier tree between
//                two requesters. Two-stage valid/ready pipeline: S1 drives the
//                tree operands, S2 captures the product and drives the
//                response. Full backpressure, one product per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_sched #(
    parameter int W    = 58,
    parameter int TAGW = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mul_sched_if.slave  bus
);
    localparam int c_PW = 2 * W;

    // stage 1: operands on the tree inputs
    logic            s1_valid_q, s1_valid_d;
    logic            s1_id_q,    s1_id_d;
    logic [TAGW-1:0] s1_tag_q,   s1_tag_d;
    logic [W-1:0]    mt_a_q,     mt_a_d;
    logic [W-1:0]    mt_b_q,     mt_b_d;
    // stage 2: captured product on the response port
    logic            s2_valid_q, s2_valid_d;
    logic            s2_id_q,    s2_id_d;
    logic [TAGW-1:0] s2_tag_q,   s2_tag_d;
    logic [c_PW-1:0] s2_prod_q,  s2_prod_d;
    // arbitration history and occupancy
    logic            rr_last_q,  rr_last_d;
    logic [1:0]      inflight_q, inflight_d;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_grant;
    logic w_in0_ready;
    logic w_in1_ready;
    logic w_hs;

    // Pipeline advance and round-robin grant; readies are held low during reset
    always_comb begin
        w_s2_adv = !s2_valid_q || bus.rsp_ready;
        w_s1_adv = !s1_valid_q || w_s2_adv;
        if (bus.in0_valid && bus.in1_valid) begin
            w_grant = !rr_last_q;
        end else if (bus.in1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
        w_in0_ready = w_s1_adv && !reset && !w_grant;
        w_in1_ready = w_s1_adv && !reset &&  w_grant;
        w_hs        = (bus.in0_valid && w_in0_ready) || (bus.in1_valid && w_in1_ready);
    end

    // Next-state for both stages; S1 operands only change on a new accept so
    // the tree output stays valid while S1 is stalled
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_tag_d   = s1_tag_q;
        mt_a_d     = mt_a_q;
        mt_b_d     = mt_b_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_tag_d   = s2_tag_q;
        s2_prod_d  = s2_prod_q;
        rr_last_d  = rr_last_q;

        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_id_d   = s1_id_q;
                s2_tag_d  = s1_tag_q;
                s2_prod_d = bus.mt_out;
            end
        end

        if (w_s1_adv) begin
            s1_valid_d = w_hs;
            if (w_hs) begin
                s1_id_d   = w_grant;
                s1_tag_d  = w_grant ? bus.in1_tag : bus.in0_tag;
                mt_a_d    = w_grant ? bus.in1_a   : bus.in0_a;
                mt_b_d    = w_grant ? bus.in1_b   : bus.in0_b;
                rr_last_d = w_grant;
            end
        end

        inflight_d = {1'b0, s1_valid_d} + {1'b0, s2_valid_d};
    end

    // State registers; asynchronous reset discards all in-flight work
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= 1'b0;
            s1_tag_q   <= '0;
            mt_a_q     <= '0;
            mt_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= 1'b0;
            s2_tag_q   <= '0;
            s2_prod_q  <= '0;
            rr_last_q  <= 1'b1;   // port 0 wins the first tie
            inflight_q <= 2'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_tag_q   <= s1_tag_d;
            mt_a_q     <= mt_a_d;
            mt_b_q     <= mt_b_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_tag_q   <= s2_tag_d;
            s2_prod_q  <= s2_prod_d;
            rr_last_q  <= rr_last_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.in0_ready = w_in0_ready;
    assign bus.in1_ready = w_in1_ready;
    assign bus.mt_a      = mt_a_q;
    assign bus.mt_b      = mt_b_q;
    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_id    = s2_id_q;
    assign bus.rsp_tag   = s2_tag_q;
    assign bus.rsp_prod  = s2_prod_q;
    assign bus.inflight  = inflight_q;

endmodule
`default_nettype wire

// File: doc/mul_sched.md
Name: mul_sched

Overview:
Round-robin scheduler that shares the single 58x58 multiplier tree (multree) between two requesters: port 0 is the FP multiply path and port 1 is the divide/Newton iteration path. It accepts operands through valid/ready handshakes and registers them onto the tree inputs. It captures the 116-bit product and returns it on one response port, tagged with requester ID and a requester-supplied tag. The block is a two-stage valid/ready pipeline with full backpressure and a throughput of 1 product per cycle.

Parameters:
W, 58, operand width (tree input width); product width is 2*W.
TAGW, 4, width of requester-supplied tag carried alongside each operation.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
in0_valid  input  1  requester 0 operand valid.
in0_ready  output  1  requester 0 accepted this cycle when valid&ready.
in0_a, in0_b  input  W  requester 0 operands.
in0_tag  input  TAGW  requester 0 tag.
in1_valid, in1_ready, in1_a, in1_b, in1_tag  same as port 0, for requester 1.
mt_a, mt_b  output  W  registered operands driven to external multree.
mt_out  input  2*W  combinational product returned from multree.
rsp_valid  output  1  response valid.
rsp_ready  input  1  consumer ready.
rsp_id  output  1  requester that issued the operation (0/1).
rsp_tag  output  TAGW  tag of the operation.
rsp_prod  output  2*W  product a*b, unsigned.
inflight  output  2  number of occupied pipeline stages (0..2).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: s1_valid=0, s2_valid=0, rsp_valid=0, mt_a=mt_b=0, rsp_prod=0, rsp_id=0, rsp_tag=0, inflight=0, rr_last=1 (port 0 wins the first tie).
- Reset mid-operation: in-flight operations are discarded and no response is issued. in*_ready deasserts while reset is high.
- Stage 1 (S1) holds valid, id, tag and drives mt_a/mt_b. Stage 2 (S2) holds valid, id, tag and prod; S2 drives rsp_*.
- Advance rules, all combinational:
  - s2_adv = !s2_valid | rsp_ready
  - s1_adv = !s1_valid | s2_adv
  - accept = s1_adv.
- Arbitration, evaluated only when accept=1:
  - Only one requester valid: grant it.
  - Both valid: grant !rr_last.
  - rr_last updates to the granted ID only on an actual handshake.
- in0_ready = accept & grant==0 & in0_valid-or-winner. More precisely, inX_ready = accept & (grant==X).
  - When neither requester is valid, both readies equal the port's eligibility: in0_ready=accept & !(in1_valid & rr_last==1 & ...). Simplification adopted: with no valids, in0_ready=accept and in1_ready=0.
  - At most one ready is ever asserted.
- On handshake at edge k: S1 loads operands, id and tag.
- Edge k+1 (if s2_adv): S2 captures mt_out, id and tag; rsp_valid=1 from then on.
- Minimum latency is 2 cycles from handshake edge to first cycle rsp_valid is high after edge k+1.
- Back-to-back issue sustains 1/cycle while rsp_ready=1.
- Backpressure: while rsp_valid & !rsp_ready:
  - rsp_* hold stable;
  - S1 holds, and mt_a/mt_b stay stable so mt_out stays valid;
  - a new accept occurs only if S1 is empty.
- Simultaneous events: an S2 drain and an S1→S2 move happen in the same cycle, together with a new accept; nothing is lost or duplicated.
- inflight = s1_valid + s2_valid, registered view.
- Ordering: responses leave in acceptance order. The tag is passed through unmodified.
- Arithmetic: unsigned; rsp_prod is the full 2*W bits with no truncation.

Test Plan:
- Port0 a=12,b=12, rsp_ready=1 -> rsp_valid 2 cycles after handshake, rsp_prod=144, rsp_id=0, tag echoed.
- Port1 a=2,b=1 issued while port0 idle -> rsp_prod=2, rsp_id=1. Then a=2^57,b=2^57 -> rsp_prod has only bit 114 set. Then a=b=2^58-1 -> rsp_prod=2^116-2^59+1.
- Both ports valid continuously for 6 cycles with tags 0..5 -> grants alternate 0,1,0,1,0,1 (first grant port 0); six responses in order at 1/cycle; products match the a*b model.
- rsp_ready=0 for 5 cycles with both ports valid -> exactly 2 operations accepted, inflight=2, rsp_* stable. On release, responses drain in order and issue resumes with no gap.
- Assert reset while inflight=2 -> rsp_valid=0 immediately (async), inflight=0, in*_ready=0. After release, no stale response appears and the first tie goes to port 0.
- Port0 a=0xAAA…(alternating 1010, 58b), b=0xCCC…(1100 pattern) -> rsp_prod equals the 116-bit unsigned model product.
